ahb3lite_interconnect_master_port: RTL and testbench

Upstream neighbour of the interconnect slave port: one instance per AHB master. Decodes the master's address against per-slave base/mask windows and drives a one-hot HSEL toward the SLAVES slave ports. Holds the address phase while the targeted slave port has not granted this master, and returns the data-phase response of whichever slave port owns the current data phase. Issues a two-cycle ERROR when no slave window matches.

---
 rtl/ahb3lite_pkg.sv | 19 +
 rtl/ahb3lite_interconnect_addr_decoder.sv | 26 ++
 rtl/ahb3lite_interconnect_master_port.sv | 159 +++++++++++++++
 tb/tb_ahb3lite_interconnect_master_port.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared AHB3-Lite encodings and the interconnect master-port state
package ahb3lite_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;
   typedef enum logic [1:0] {MP_IDLE, MP_PENDING, MP_ERR1, MP_ERR2} mst_port_state_t;
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ahb3lite_interconnect_addr_decoder.sv
// ahb3lite_interconnect_addr_decoder: base/mask window match, lowest index wins
module ahb3lite_interconnect_addr_decoder
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int SLAVES     = 8
)(
   input  logic                           sel,
   input  logic [HADDR_SIZE-1:0]          addr,
   input  logic [HADDR_SIZE-1:0]          base [SLAVES],
   input  logic [HADDR_SIZE-1:0]          mask [SLAVES],
   output logic                           hit,
   output logic [idx_width(SLAVES)-1:0]   hit_idx
);
   // scan from the top so the lowest-indexed matching window is the one left standing
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
         if (sel && ((addr & mask[s]) == (base[s] & mask[s]))) begin
            hit     = 1'b1;
            hit_idx = idx_width(SLAVES)'(s);
         end
      end
   end
endmodule

// File: rtl/ahb3lite_interconnect_master_port.sv
// ahb3lite_interconnect_master_port: per-master decode, grant wait and response return
module ahb3lite_interconnect_master_port
   import ahb3lite_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MASTERS    = 3,
   parameter int SLAVES     = 8
)(
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [$clog2(MASTERS-1):0]   mst_priority,
   input  logic                         HSEL,
   input  logic [HADDR_SIZE-1:0]        HADDR,
   input  logic [HDATA_SIZE-1:0]        HWDATA,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [2:0]                   HBURST,
   input  logic [3:0]                   HPROT,
   input  logic [1:0]                   HTRANS,
   input  logic                         HMASTLOCK,
   input  logic                         HREADY,
   output logic [HDATA_SIZE-1:0]        HRDATA,
   output logic                         HREADYOUT,
   output logic                         HRESP,
   input  logic [HADDR_SIZE-1:0]        slvHADDRbase [SLAVES],
   input  logic [HADDR_SIZE-1:0]        slvHADDRmask [SLAVES],
   output logic [$clog2(MASTERS-1):0]   slvpriority,
   output logic [SLAVES-1:0]            slvHSEL,
   output logic [HADDR_SIZE-1:0]        slvHADDR,
   output logic [HDATA_SIZE-1:0]        slvHWDATA,
   output logic                         slvHWRITE,
   output logic [2:0]                   slvHSIZE,
   output logic [2:0]                   slvHBURST,
   output logic [3:0]                   slvHPROT,
   output logic [1:0]                   slvHTRANS,
   output logic                         slvHMASTLOCK,
   output logic                         slvHREADY,
   input  logic [HDATA_SIZE-1:0]        slvHRDATA [SLAVES],
   input  logic [SLAVES-1:0]            slvHREADYOUT,
   input  logic [SLAVES-1:0]            slvHRESP,
   output logic [SLAVES-1:0]            can_switch,
   input  logic [SLAVES-1:0]            granted
);
   localparam int SW = idx_width(SLAVES);
   localparam int HW = HADDR_SIZE + 12 + SW;

   mst_port_state_t        state_q, state_d;
   logic                   dvalid_q, dvalid_d;
   logic [SW-1:0]          dslv_q, dslv_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   hit;
   logic [SW-1:0]          hit_idx;
   logic [HADDR_SIZE-1:0]  h_addr;
   logic                   h_write;
   logic [2:0]             h_size;
   logic [2:0]             h_burst;
   logic [3:0]             h_prot;
   logic                   h_lock;
   logic [SW-1:0]          h_slv;
   logic                   lready;
   logic                   accept;
   logic                   active;
   logic                   busy_fwd;
   logic                   pend;
   logic                   sel_en;
   logic [SW-1:0]          sel_idx;

   ahb3lite_interconnect_addr_decoder #(
      .HADDR_SIZE (HADDR_SIZE),
      .SLAVES     (SLAVES)
   ) u_dec (
      .sel     (HSEL),
      .addr    (HADDR),
      .base    (slvHADDRbase),
      .mask    (slvHADDRmask),
      .hit     (hit),
      .hit_idx (hit_idx)
   );

   assign {h_addr, h_write, h_size, h_burst, h_prot, h_lock, h_slv} = hold_q;
   assign lready   = dvalid_q ? slvHREADYOUT[dslv_q] : 1'b1;
   assign accept   = HREADY & lready;
   assign active   = HSEL & HTRANS[1];
   assign busy_fwd = HSEL & (HTRANS == HTRANS_BUSY) & dvalid_q;
   assign pend     = (state_q == MP_PENDING);

   // next state, data-phase owner, hold capture and which slave port sees the address
   always_comb begin
      state_d  = state_q;
      dvalid_d = dvalid_q;
      dslv_d   = dslv_q;
      hold_d   = hold_q;
      sel_en   = 1'b0;
      sel_idx  = hit_idx;
      case (state_q)
         MP_IDLE: begin
            sel_en  = (active & hit & granted[hit_idx]) | busy_fwd;
            sel_idx = busy_fwd ? dslv_q : hit_idx;
            if (accept) begin
               dvalid_d = sel_en;
               dslv_d   = sel_idx;
               if (active && !hit)
                  state_d = MP_ERR1;
               else if (active && !granted[hit_idx]) begin
                  hold_d  = {HADDR, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, hit_idx};
                  state_d = MP_PENDING;
               end
            end
         end
         MP_PENDING: begin
            sel_en  = 1'b1;
            sel_idx = h_slv;
            if (granted[h_slv]) begin
               dvalid_d = 1'b1;
               dslv_d   = h_slv;
               state_d  = MP_IDLE;
            end
         end
         MP_ERR1: state_d = MP_ERR2;
         default: state_d = MP_IDLE;
      endcase
   end

   // present the held or live address phase and route the data-phase response back
   always_comb begin
      slvHSEL      = sel_en ? (SLAVES'(1'b1) << sel_idx) : '0;
      slvHADDR     = pend ? h_addr : HADDR;
      slvHWRITE    = pend ? h_write : HWRITE;
      slvHSIZE     = pend ? h_size : HSIZE;
      slvHBURST    = pend ? h_burst : HBURST;
      slvHPROT     = pend ? h_prot : HPROT;
      slvHTRANS    = pend ? HTRANS_NONSEQ : HTRANS;
      slvHMASTLOCK = pend ? h_lock : HMASTLOCK;
      slvHWDATA    = HWDATA;
      slvHREADY    = lready;
      slvpriority  = mst_priority;
      can_switch   = {SLAVES{~slvHMASTLOCK}} &
                     ~(slvHSEL & {SLAVES{(slvHTRANS == HTRANS_SEQ) | (slvHTRANS == HTRANS_BUSY)}});
      HRDATA       = dvalid_q ? slvHRDATA[dslv_q] : '0;
      HREADYOUT    = (state_q == MP_IDLE) ? lready : (state_q == MP_ERR2);
      HRESP        = (state_q == MP_IDLE) ? (dvalid_q & slvHRESP[dslv_q]) : !pend;
   end

   // state, data-phase owner and hold register; reset drops any held or erroring transfer
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= MP_IDLE;
         dvalid_q <= 1'b0;
         dslv_q   <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         dvalid_q <= dvalid_d;
         dslv_q   <= dslv_d;
         hold_q   <= hold_d;
      end
   end
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// tb_ahb3lite_interconnect_master_port: directed and randomized transfers against a window/grant model
module tb_ahb3lite_interconnect_master_port;
   import ahb3lite_pkg::*;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic [1:0]     mst_priority, slvpriority;
   logic           HSEL, HWRITE, HMASTLOCK, HREADY;
   logic [AW-1:0]  HADDR;
   logic [DW-1:0]  HWDATA, HRDATA;
   logic [2:0]     HSIZE, HBURST;
   logic [3:0]     HPROT;
   logic [1:0]     HTRANS;
   logic           HREADYOUT, HRESP;
   logic [AW-1:0]  base [NS];
   logic [AW-1:0]  mask [NS];
   logic [NS-1:0]  slvHSEL, slvHREADYOUT, slvHRESP, can_switch, granted;
   logic [AW-1:0]  slvHADDR;
   logic [DW-1:0]  slvHWDATA;
   logic           slvHWRITE, slvHMASTLOCK, slvHREADY;
   logic [2:0]     slvHSIZE, slvHBURST;
   logic [3:0]     slvHPROT;
   logic [1:0]     slvHTRANS;
   logic [DW-1:0]  slvHRDATA [NS];
   logic [DW-1:0]  rdata [NS];
   logic [1:0]     btr [6];
   logic [AW-1:0]  badr [6];
   logic [AW-1:0]  ra;
   int             checks = 0;
   int             errors = 0;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb3lite_interconnect_master_port #(
      .HADDR_SIZE (AW), .HDATA_SIZE (DW), .MASTERS (3), .SLAVES (NS)
   ) dut (
      .HCLK (HCLK), .HRESET (HRESET), .mst_priority (mst_priority),
      .HSEL (HSEL), .HADDR (HADDR), .HWDATA (HWDATA), .HWRITE (HWRITE),
      .HSIZE (HSIZE), .HBURST (HBURST), .HPROT (HPROT), .HTRANS (HTRANS),
      .HMASTLOCK (HMASTLOCK), .HREADY (HREADY),
      .HRDATA (HRDATA), .HREADYOUT (HREADYOUT), .HRESP (HRESP),
      .slvHADDRbase (base), .slvHADDRmask (mask), .slvpriority (slvpriority),
      .slvHSEL (slvHSEL), .slvHADDR (slvHADDR), .slvHWDATA (slvHWDATA),
      .slvHWRITE (slvHWRITE), .slvHSIZE (slvHSIZE), .slvHBURST (slvHBURST),
      .slvHPROT (slvHPROT), .slvHTRANS (slvHTRANS), .slvHMASTLOCK (slvHMASTLOCK),
      .slvHREADY (slvHREADY), .slvHRDATA (slvHRDATA), .slvHREADYOUT (slvHREADYOUT),
      .slvHRESP (slvHRESP), .can_switch (can_switch), .granted (granted)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic probe();
      @(negedge HCLK);
   endtask

   function automatic int model_slave(input logic [AW-1:0] a);
      for (int s = 0; s < NS; s++)
         if ((a & mask[s]) == (base[s] & mask[s])) return s;
      return -1;
   endfunction

   function automatic logic [NS-1:0] onehot(input int s);
      logic [NS-1:0] v = '0;
      if (s >= 0) v[s] = 1'b1;
      return v;
   endfunction

   task automatic run_xfer(input logic [AW-1:0] a, input bit gnt, input int wpend, input int ws);
      int s = model_slave(a);
      logic [NS-1:0] sel = onehot(s);
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HBURST = HBURST_SINGLE;
      HWRITE = 1'b0; HMASTLOCK = 1'b0;
      granted = gnt ? sel : '0;
      probe();
      chk("addr_hsel", slvHSEL, gnt ? sel : '0);
      chk("addr_ready", HREADYOUT, 1);
      if (gnt && s >= 0) chk("addr_live", slvHADDR, a);
      tick();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = ~a; granted = '0;
      if (s < 0) begin
         probe();
         chk("err1_ready", HREADYOUT, 0); chk("err1_resp", HRESP, 1); chk("err1_hsel", slvHSEL, 0);
         tick();
         probe();
         chk("err2_ready", HREADYOUT, 1); chk("err2_resp", HRESP, 1);
         tick();
         probe();
         chk("err_done_ready", HREADYOUT, 1); chk("err_done_resp", HRESP, 0);
         tick();
         return;
      end
      if (!gnt) begin
         for (int i = 0; i <= wpend; i++) begin
            if (i == wpend) granted = sel;
            probe();
            chk("pend_ready", HREADYOUT, 0); chk("pend_resp", HRESP, 0);
            chk("pend_hsel", slvHSEL, sel); chk("pend_addr", slvHADDR, a);
            chk("pend_trans", slvHTRANS, HTRANS_NONSEQ); chk("pend_state", dut.state_q, MP_PENDING);
            tick();
         end
         granted = '0;
      end
      for (int i = 0; i <= ws; i++) begin
         slvHREADYOUT[s] = (i == ws);
         probe();
         chk("data_ready", HREADYOUT, i == ws);
         if (i == ws) begin
            chk("data_rdata", HRDATA, rdata[s]);
            chk("data_resp", HRESP, 0);
         end
         tick();
      end
      slvHREADYOUT = '1;
   endtask

   initial begin
      base[0] = 32'h0000; mask[0] = 32'hF000;
      base[1] = 32'h1000; mask[1] = 32'hF000;
      base[2] = 32'h2000; mask[2] = 32'hF000;
      base[3] = 32'h2000; mask[3] = 32'hE000;
      for (int s = 0; s < NS; s++) begin
         rdata[s] = $urandom;
         slvHRDATA[s] = rdata[s];
      end
      HRESET = 1'b1; mst_priority = 2'd2;
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
      HSIZE = 3'b010; HBURST = HBURST_SINGLE; HPROT = 4'b0011; HMASTLOCK = 1'b0;
      granted = '0; slvHREADYOUT = '1; slvHRESP = '0;
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      probe();
      chk("rst_state", dut.state_q, MP_IDLE);
      chk("rst_ready", HREADYOUT, 1);
      chk("rst_resp", HRESP, 0);
      chk("rst_hsel", slvHSEL, 0);
      chk("rst_can_switch", can_switch, 4'hF);
      chk("priority", slvpriority, 2'd2);
      tick();
      run_xfer(32'h2010, 1'b1, 0, 0);
      run_xfer(32'h2010, 1'b0, 3, 0);
      run_xfer(32'h9000, 1'b0, 0, 0);
      run_xfer(32'h3FFC, 1'b1, 0, 1);
      run_xfer(32'h2FFC, 1'b0, 0, 2);
      run_xfer(32'h4000, 1'b1, 0, 0);
      btr[0] = HTRANS_NONSEQ; btr[1] = HTRANS_SEQ; btr[2] = HTRANS_BUSY;
      btr[3] = HTRANS_SEQ;    btr[4] = HTRANS_SEQ; btr[5] = HTRANS_IDLE;
      badr[0] = 32'h1000; badr[1] = 32'h1004; badr[2] = 32'h1008;
      badr[3] = 32'h1008; badr[4] = 32'h100C; badr[5] = 32'h0000;
      granted = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         HSEL = (i < 5); HTRANS = btr[i]; HADDR = badr[i]; HBURST = HBURST_INCR4;
         HWRITE = 1'b1; HWDATA = $urandom;
         probe();
         chk("burst_cs1", can_switch[1], !(btr[i] == HTRANS_SEQ || btr[i] == HTRANS_BUSY));
         chk("burst_hsel", slvHSEL, (i < 5) ? 4'b0010 : 4'b0000);
         chk("burst_wdata", slvHWDATA, HWDATA);
         if (i > 0) chk("burst_rdata", HRDATA, rdata[1]);
         tick();
      end
      HWRITE = 1'b0;
      granted = 4'b0001; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h0040;
      HBURST = HBURST_SINGLE; HMASTLOCK = 1'b1;
      probe();
      chk("lock_hsel", slvHSEL, 4'b0001);
      chk("lock_cs0_addr", can_switch[0], 0);
      tick();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      probe();
      chk("lock_cs0_data", can_switch[0], 0);
      chk("lock_rdata", HRDATA, rdata[0]);
      tick();
      HMASTLOCK = 1'b0;
      probe();
      chk("unlock_cs", can_switch, 4'hF);
      tick();
      granted = '0; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h2010;
      probe();
      tick();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE; HRESET = 1'b1; granted = 4'b0100;
      probe();
      chk("rstpend_state", dut.state_q, MP_PENDING);
      chk("rstpend_ready", HREADYOUT, 0);
      tick();
      HRESET = 1'b0;
      probe();
      chk("rstpend_after_state", dut.state_q, MP_IDLE);
      chk("rstpend_after_hsel", slvHSEL, 0);
      chk("rstpend_after_ready", HREADYOUT, 1);
      chk("rstpend_after_resp", HRESP, 0);
      tick();
      probe();
      chk("rstpend_noxfer_hsel", slvHSEL, 0);
      chk("rstpend_noxfer_ready", HREADYOUT, 1);
      chk("rstpend_noxfer_rdata", HRDATA, 0);
      tick();
      granted = '0;
      for (int n = 0; n < 24; n++) begin
         for (int s = 0; s < NS; s++) begin
            rdata[s] = $urandom;
            slvHRDATA[s] = rdata[s];
         end
         ra = $urandom;
         ra[15] = ($urandom_range(0, 3) == 0);
         ra[14] = 1'b0;
         run_xfer(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 2));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
